// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-slot TDM demultiplexer: slot stream in, per-channel results out.
// Optional parity signals appear only when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux4_if #(parameter int WIDTH = 4);
  logic             ena;
  logic             sync_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] ch0_o;
  logic [WIDTH-1:0] ch1_o;
  logic [WIDTH-1:0] ch2_o;
  logic [WIDTH-1:0] ch3_o;
  logic [3:0]       ch_vld_o;
  logic             frame_o;
  logic             locked_o;
  logic             sync_err_o;
`ifdef TDM_DEMUX_PARITY_EN
  logic             par_i;
  logic             par_err_o;
`endif

  modport master (
    output ena, sync_i, data_i,
    input  ch0_o, ch1_o, ch2_o, ch3_o, ch_vld_o, frame_o, locked_o, sync_err_o
`ifdef TDM_DEMUX_PARITY_EN
    , output par_i, input par_err_o
`endif
  );

  modport slave (
    input  ena, sync_i, data_i,
    output ch0_o, ch1_o, ch2_o, ch3_o, ch_vld_o, frame_o, locked_o, sync_err_o
`ifdef TDM_DEMUX_PARITY_EN
    , input par_i, output par_err_o
`endif
  );
endinterface

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer with HUNT/LOCKED frame tracking and miss-count loss of lock.
// Define TDM_DEMUX_PARITY_EN to add per-slot even-parity checking (par_i / par_err_o).
module tdm_demux4 #(
  parameter int WIDTH    = 4,
  parameter int MISS_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux4_if.slave bus
);
  localparam int MW = $clog2(MISS_MAX + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [WIDTH-1:0] ch_q [4];
  logic [WIDTH-1:0] ch_d [4];
  logic [3:0]       vld_q, vld_d;
  logic             frame_q, frame_d;
  logic             serr_q, serr_d;
  logic             cap_en, serr_hit, par_ok;
  logic [1:0]       cap_sel;

`ifdef TDM_DEMUX_PARITY_EN
  logic perr_q, perr_d;
  assign par_ok = (bus.par_i == ^bus.data_i);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      miss_q  <= '0;
      ch_q    <= '{default: '0};
      vld_q   <= 4'd0;
      frame_q <= 1'b0;
      serr_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      frame_q <= frame_d;
      serr_q  <= serr_d;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state and capture decision; a sync seen anywhere while locked realigns to slot 0.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    miss_d   = miss_q;
    cap_en   = 1'b0;
    cap_sel  = 2'd0;
    serr_hit = 1'b0;
    if (bus.ena) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sync_i) begin
            state_d = LOCKED;
            slot_d  = 2'd1;
            miss_d  = '0;
            cap_en  = 1'b1;
          end
        end
        LOCKED: begin
          if (bus.sync_i) begin
            serr_hit = (slot_q != 2'd0);
            slot_d   = 2'd1;
            miss_d   = '0;
            cap_en   = 1'b1;
          end else if (slot_q == 2'd0) begin
            if (miss_q == MW'(MISS_MAX - 1)) begin
              state_d = HUNT;
              slot_d  = 2'd0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MW'(1);
              slot_d = 2'd1;
              cap_en = 1'b1;
            end
          end else begin
            cap_sel = slot_q;
            slot_d  = slot_q + 2'd1;
            cap_en  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ch_d    = ch_q;
    vld_d   = 4'd0;
    frame_d = 1'b0;
    serr_d  = serr_hit;
`ifdef TDM_DEMUX_PARITY_EN
    perr_d  = cap_en && !par_ok;
`endif
    if (cap_en && par_ok) begin
      ch_d[cap_sel]  = bus.data_i;
      vld_d[cap_sel] = 1'b1;
      frame_d        = (cap_sel == 2'd3);
    end
  end

  assign bus.ch0_o      = ch_q[0];
  assign bus.ch1_o      = ch_q[1];
  assign bus.ch2_o      = ch_q[2];
  assign bus.ch3_o      = ch_q[3];
  assign bus.ch_vld_o   = vld_q;
  assign bus.frame_o    = frame_q;
  assign bus.locked_o   = (state_q == LOCKED);
  assign bus.sync_err_o = serr_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_err_o  = perr_q;
`endif
endmodule
